// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM port arbiter and its sub-blocks.
// Holds default widths, FSM state encoding, port ids and the read-return tag.
package sram_pkg;

  localparam int SRAM_ADDR_W = 4;
  localparam int SRAM_DATA_W = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic vld;
    logic port;
  } rtag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-grant flop updated on any grant.
// Zero-cycle grant; a requester simply waits while the other port holds priority.
module rr_arbiter2
  import sram_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[PORT_A] && req[PORT_B]) begin
        gnt = (last_q == PORT_A) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= PORT_B;
    end else if (|gnt) begin
      last_q <= gnt[PORT_B];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between ports A and B (round-robin), tags reads back to their port, zero-fills on reset/clear.
// Grant is same-cycle; read data returns READ_LAT+1 cycles after grant; requesters hold inputs until gnt, no grants while busy.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int                ADDR_W         = SRAM_ADDR_W,
  parameter int                DATA_W         = SRAM_DATA_W,
  parameter int                READ_LAT       = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_reset
);

  localparam int     DEPTH     = 2 ** ADDR_W;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic [1:0]              gnt;
  logic                    run_en;
  rtag_t                   tag_in, tag_out;
  rtag_t [READ_LAT-1:0]    pipe_q;

  assign ram_reset = !reset_n;
  assign ram_oce   = 1'b1;

  // Gating with reset_n keeps every RAM-side output quiet while reset is held.
  assign run_en = reset_n && (state_q == ST_RUN);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run_en),
    .req     ({b_req, a_req}),
    .gnt     (gnt)
  );

  assign a_gnt = gnt[PORT_A];
  assign b_gnt = gnt[PORT_B];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = (state_q == ST_CLEAR);
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    case (state_q)
      ST_CLEAR: begin
        if (reset_n) begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_ad  = cnt_q;
          ram_din = CLEAR_VALUE;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
        end
        if (gnt[PORT_A]) begin
          ram_ce  = 1'b1;
          ram_wre = a_we;
          ram_ad  = a_addr;
          ram_din = a_wdata;
        end else if (gnt[PORT_B]) begin
          ram_ce  = 1'b1;
          ram_wre = b_we;
          ram_ad  = b_addr;
          ram_din = b_wdata;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The tag travels alongside the RAM's own read latency so it emerges with valid DOUT.
  assign tag_in.vld  = (gnt[PORT_A] && !a_we) || (gnt[PORT_B] && !b_we);
  assign tag_in.port = gnt[PORT_B];
  assign tag_out     = pipe_q[READ_LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= tag_out.vld && (tag_out.port == PORT_A);
      b_rvalid <= tag_out.vld && (tag_out.port == PORT_B);
      if (tag_out.vld && (tag_out.port == PORT_A)) begin
        a_rdata <= ram_dout;
      end
      if (tag_out.vld && (tag_out.port == PORT_B)) begin
        b_rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: bypass-read instance checked every cycle against a behavioural model,
// plus an output-register instance (READ_LAT=2) checked with literal expectations.
module tb_sram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_req, a_we, b_req, b_we, clear_start;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_ce, ram_oce, ram_wre, ram_reset;
  logic [3:0] ram_ad;
  logic [7:0] ram_din, ram_dout;

  logic       d2_a_req, d2_a_we, d2_b_req, d2_b_we, d2_clear_start;
  logic [3:0] d2_a_addr, d2_b_addr;
  logic [7:0] d2_a_wdata, d2_b_wdata;
  logic       d2_a_gnt, d2_a_rvalid, d2_b_gnt, d2_b_rvalid, d2_busy;
  logic [7:0] d2_a_rdata, d2_b_rdata;
  logic       d2_ram_ce, d2_ram_oce, d2_ram_wre, d2_ram_reset;
  logic [3:0] d2_ram_ad;
  logic [7:0] d2_ram_din, d2_ram_dout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clear_start(clear_start), .busy(busy),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_reset(ram_reset)
  );

  sram_port_arbiter #(.READ_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .a_req(d2_a_req), .a_we(d2_a_we), .a_addr(d2_a_addr), .a_wdata(d2_a_wdata),
    .a_gnt(d2_a_gnt), .a_rvalid(d2_a_rvalid), .a_rdata(d2_a_rdata),
    .b_req(d2_b_req), .b_we(d2_b_we), .b_addr(d2_b_addr), .b_wdata(d2_b_wdata),
    .b_gnt(d2_b_gnt), .b_rvalid(d2_b_rvalid), .b_rdata(d2_b_rdata),
    .clear_start(d2_clear_start), .busy(d2_busy),
    .ram_ce(d2_ram_ce), .ram_oce(d2_ram_oce), .ram_wre(d2_ram_wre), .ram_ad(d2_ram_ad),
    .ram_din(d2_ram_din), .ram_dout(d2_ram_dout), .ram_reset(d2_ram_reset)
  );

  // SRAM models: bypass read for dut, output register stage for dut2; writes leave DOUT unchanged.
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];
  logic [7:0] dout1 = 8'h00, dout2a = 8'h00, dout2b = 8'h00;
  initial for (int i = 0; i < 16; i++) begin
    mem1[i] = 8'h80 + 8'(i);
    mem2[i] = 8'hC0 + 8'(i);
  end
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem1[ram_ad] <= ram_din;
      else dout1 <= mem1[ram_ad];
    end
    if (d2_ram_ce) begin
      if (d2_ram_wre) mem2[d2_ram_ad] <= d2_ram_din;
      else dout2a <= mem2[d2_ram_ad];
    end
    if (d2_ram_oce) dout2b <= dout2a;
  end
  assign ram_dout    = dout1;
  assign d2_ram_dout = dout2b;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of dut: clear sweep, round-robin winner, shadow memory, scheduled returns.
  logic       m_clear;
  int         m_cnt;
  int         m_last;
  logic [7:0] shadow [16];
  bit         slot_v [8];
  int         slot_p [8];
  logic [7:0] slot_d [8];
  logic [7:0] exp_ard = 8'h00, exp_brd = 8'h00;

  always @(negedge clk) begin : model_cmp
    int win, s, r;
    logic we;
    logic [3:0] ad;
    logic [7:0] wd;
    logic e_ce, e_wre, e_busy, e_ag, e_bg, e_arv, e_brv;
    logic [3:0] e_ad;
    logic [7:0] e_din;
    e_ce = 0; e_wre = 0; e_busy = 0; e_ag = 0; e_bg = 0; e_arv = 0; e_brv = 0;
    e_ad = 0; e_din = 0;
    if (!reset_n) begin
      m_clear = 1; m_cnt = 0; m_last = 1; exp_ard = 0; exp_brd = 0; e_busy = 1;
      for (int i = 0; i < 8; i++) slot_v[i] = 0;
    end else begin
      s = cyc % 8;
      if (slot_v[s]) begin
        if (slot_p[s] == 0) begin e_arv = 1; exp_ard = slot_d[s]; end
        else begin e_brv = 1; exp_brd = slot_d[s]; end
        slot_v[s] = 0;
      end
      if (m_clear) begin
        e_busy = 1; e_ce = 1; e_wre = 1; e_ad = 4'(m_cnt); e_din = 8'h00;
        shadow[m_cnt] = 8'h00;
        m_cnt++;
        if (m_cnt == 16) begin m_clear = 0; m_cnt = 0; end
      end else begin
        win = -1;
        if (a_req && b_req) win = (m_last == 1) ? 0 : 1;
        else if (a_req) win = 0;
        else if (b_req) win = 1;
        if (win >= 0) begin
          we = (win == 0) ? a_we : b_we;
          ad = (win == 0) ? a_addr : b_addr;
          wd = (win == 0) ? a_wdata : b_wdata;
          if (win == 0) e_ag = 1; else e_bg = 1;
          e_ce = 1; e_wre = we; e_ad = ad; e_din = wd;
          m_last = win;
          if (we) shadow[ad] = wd;
          else begin
            r = (cyc + 2) % 8;
            slot_v[r] = 1; slot_p[r] = win; slot_d[r] = shadow[ad];
          end
        end
        if (clear_start) begin m_clear = 1; m_cnt = 0; end
      end
    end
    chk("a_gnt", a_gnt, e_ag);
    chk("b_gnt", b_gnt, e_bg);
    chk("busy", busy, e_busy);
    chk("ram_ce", ram_ce, e_ce);
    chk("ram_wre", ram_wre, e_wre);
    chk("ram_ad", ram_ad, e_ad);
    chk("ram_din", ram_din, e_din);
    chk("ram_oce", ram_oce, 1);
    chk("ram_reset", ram_reset, !reset_n);
    chk("a_rvalid", a_rvalid, e_arv);
    chk("b_rvalid", b_rvalid, e_brv);
    chk("a_rdata", a_rdata, exp_ard);
    chk("b_rdata", b_rdata, exp_brd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles from the next negedge on; returns at the first non-busy negedge.
  task automatic wait_clear(input string nm, input int already);
    int n;
    n = already;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk(nm, n, 16);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int seen, lat;
    reset_n = 0; clear_start = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    d2_a_req = 0; d2_a_we = 0; d2_a_addr = 0; d2_a_wdata = 0;
    d2_b_req = 0; d2_b_we = 0; d2_b_addr = 0; d2_b_wdata = 0; d2_clear_start = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    wait_clear("busy_cycles_after_reset", 0);

    // read of address 7 after the zero-fill
    tick(); a_req = 1; a_we = 0; a_addr = 4'd7;
    @(negedge clk); chk("t1_a_gnt", a_gnt, 1);
    tick(); a_req = 0;
    @(negedge clk); @(negedge clk);
    chk("t1_a_rvalid", a_rvalid, 1); chk("t1_a_rdata", a_rdata, 8'h00);

    // A writes 0xA5 to 3, B reads 3 next cycle
    tick(); a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 8'hA5;
    @(negedge clk); chk("t2_a_gnt", a_gnt, 1);
    tick(); a_req = 0; a_we = 0; b_req = 1; b_we = 0; b_addr = 4'd3;
    @(negedge clk); chk("t2_b_gnt", b_gnt, 1); chk("t2_a_gnt_low", a_gnt, 0);
    tick(); b_req = 0;
    @(negedge clk); chk("t2_b_rvalid_early", b_rvalid, 0);
    @(negedge clk);
    chk("t2_b_rvalid", b_rvalid, 1); chk("t2_b_rdata", b_rdata, 8'hA5);
    chk("t2_a_rvalid", a_rvalid, 0);

    // both ports request continuously: A,B,A,B,A,B
    tick(); a_req = 1; a_we = 0; a_addr = 4'd3; b_req = 1; b_we = 0; b_addr = 4'd7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_a_gnt", a_gnt, (i % 2 == 0) ? 1 : 0);
      chk("t3_b_gnt", b_gnt, (i % 2 == 1) ? 1 : 0);
      if (i == 2) begin chk("t3_a_rvalid", a_rvalid, 1); chk("t3_a_rdata", a_rdata, 8'hA5); end
      if (i == 3) begin chk("t3_b_rvalid", b_rvalid, 1); chk("t3_b_rdata", b_rdata, 8'h00); end
      if (i < 5) tick();
    end
    tick(); a_req = 0; b_req = 0;
    repeat (3) tick();

    // clear_start right after an A read of address 5 holding 0x3C
    a_req = 1; a_we = 1; a_addr = 4'd5; a_wdata = 8'h3C;
    @(negedge clk); chk("t4_wr_gnt", a_gnt, 1);
    tick(); a_we = 0;
    @(negedge clk); chk("t4_rd_gnt", a_gnt, 1);
    tick(); a_req = 0; clear_start = 1;
    @(negedge clk); chk("t4_busy_before", busy, 0);
    tick(); clear_start = 0; a_req = 1; a_we = 0; a_addr = 4'd5;
    @(negedge clk);
    chk("t4_a_rvalid", a_rvalid, 1); chk("t4_a_rdata", a_rdata, 8'h3C);
    chk("t4_busy", busy, 1); chk("t4_no_gnt", a_gnt, 0);
    wait_clear("t4_busy_cycles", 1);
    chk("t4_regrant", a_gnt, 1);
    tick(); a_req = 0;
    @(negedge clk); @(negedge clk);
    chk("t4_reread_rvalid", a_rvalid, 1); chk("t4_reread_rdata", a_rdata, 8'h00);

    // reset dropped while a read is in flight
    tick(); a_req = 1; a_we = 0; a_addr = 4'd3;
    @(negedge clk); chk("t5_a_gnt", a_gnt, 1);
    tick(); a_req = 0; reset_n = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_rvalid || b_rvalid) seen++;
    end
    chk("t5_no_rvalid", seen, 0); chk("t5_a_rdata", a_rdata, 8'h00);
    chk("t5_ram_ce", ram_ce, 0); chk("t5_ram_reset", ram_reset, 1);
    @(posedge clk); #1 reset_n = 1;
    wait_clear("t5_busy_cycles", 0);

    // READ_LAT=2 instance: write 0x5A to 1, read back
    tick(); d2_a_req = 1; d2_a_we = 1; d2_a_addr = 4'd1; d2_a_wdata = 8'h5A;
    @(negedge clk); chk("t6_wr_gnt", d2_a_gnt, 1);
    tick(); d2_a_we = 0;
    @(negedge clk); chk("t6_rd_gnt", d2_a_gnt, 1);
    tick(); d2_a_req = 0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (d2_a_rvalid) begin lat = i; break; end
    end
    chk("t6_latency", lat, 3); chk("t6_a_rdata", d2_a_rdata, 8'h5A);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
